struct_lane_serializer: RTL and testbench

- Consumes the packed word produced by the lane-packing stage: LANES records of {last, middle, first}, with lane k at bits [k*REC_W +: REC_W].
- Accepts a word over a valid/ready handshake.
- Emits the records one per handshake, lane 0 first, with the fields unpacked.
- Checks each record's index fields against its lane position and counts mismatches.

---
 rtl/struct_lane_serializer.sv | 132 +++++++++++++
 tb/tb_struct_lane_serializer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/struct_lane_serializer.sv
// struct_lane_serializer
// Takes one packed word of LANES {last, middle, first} records and streams the
// records out one per handshake, lane 0 first. Each record's first/last fields
// are checked against its lane position, and mismatching records are counted.

module struct_lane_serializer #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned FIRST_W = 2,
    parameter int unsigned MID_W   = 4,
    parameter int unsigned LAST_W  = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [LANES*(FIRST_W+MID_W+LAST_W)-1:0]        in_all,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [FIRST_W-1:0]                            out_first,
    output logic [MID_W-1:0]                              out_middle,
    output logic [LAST_W-1:0]                             out_last,
    output logic [$clog2(LANES)-1:0]                      out_lane,
    output logic                                          out_eop,
    output logic                                          out_err,
    output logic [7:0]                                    err_count
);

    localparam int unsigned REC_W  = FIRST_W + MID_W + LAST_W;
    localparam int unsigned WORD_W = LANES * REC_W;
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              r_state;
    logic [LANE_W-1:0]   r_lane;
    logic [WORD_W-1:0]   r_word;
    logic [CNT_W-1:0]    r_err_count;

    logic [REC_W-1:0]    w_rec;
    logic [FIRST_W-1:0]  w_first;
    logic [MID_W-1:0]    w_middle;
    logic [LAST_W-1:0]   w_last;
    logic [FIRST_W-1:0]  w_exp_first;
    logic [LAST_W-1:0]   w_exp_last;
    logic                w_mismatch;
    logic                w_lane_last;
    logic                w_send;
    logic                w_in_xfer;
    logic                w_out_xfer;

    // Select the record addressed by the current lane from the captured word
    always_comb begin
        w_rec = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            if (r_lane == LANE_W'(k)) begin
                w_rec = r_word[k*REC_W +: REC_W];
            end
        end
    end

    assign w_first  = w_rec[FIRST_W-1:0];
    assign w_middle = w_rec[FIRST_W +: MID_W];
    assign w_last   = w_rec[REC_W-1 -: LAST_W];

    // Index fields a well-formed record carries at this lane position
    assign w_exp_first = FIRST_W'(r_lane);
    assign w_exp_last  = LAST_W'(32'(LANES - 1) - 32'(r_lane));
    assign w_mismatch  = (w_first != w_exp_first) || (w_last != w_exp_last);

    assign w_send      = (r_state == SEND);
    assign w_lane_last = (r_lane == LANE_W'(LANES - 1));

    // Ready in IDLE, or on the final-lane transfer so words can run back-to-back
    assign in_ready   = !rst && ((r_state == IDLE) || (w_send && w_lane_last && out_ready));
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = w_send && out_ready;

    assign out_valid  = w_send;
    assign out_first  = w_first;
    assign out_middle = w_middle;
    assign out_last   = w_last;
    assign out_lane   = r_lane;
    assign out_eop    = w_send && w_lane_last;
    assign out_err    = w_send && w_mismatch;
    assign err_count  = r_err_count;

    // Capture/sequence FSM plus saturating error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lane      <= '0;
            r_word      <= '0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_in_xfer) begin
                        r_word  <= in_all;
                        r_lane  <= '0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_out_xfer) begin
                        if (!w_lane_last) begin
                            r_lane <= r_lane + LANE_W'(1);
                        end else if (w_in_xfer) begin
                            r_word <= in_all;
                            r_lane <= '0;
                        end else begin
                            r_lane  <= '0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_lane  <= '0;
                end
            endcase

            if (w_out_xfer && w_mismatch && (r_err_count != {CNT_W{1'b1}})) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_struct_lane_serializer.sv
// Directed bench for struct_lane_serializer (default parameters: 4 lanes, 2/4/2 fields).
`timescale 1ns/1ps

module tb_struct_lane_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_all;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_first;
    logic [3:0]  out_middle;
    logic [1:0]  out_last;
    logic [1:0]  out_lane;
    logic        out_eop;
    logic        out_err;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] W1   = 32'h2B6AA9E8; // mids A,A,A,A
    localparam logic [31:0] W2   = 32'h2B5A99D8; // mids 6,6,6,A
    localparam logic [31:0] WERR = 32'h2B68A9E8; // lane 2 first=0

    struct_lane_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_all     (in_all),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_first  (out_first),
        .out_middle (out_middle),
        .out_last   (out_last),
        .out_lane   (out_lane),
        .out_eop    (out_eop),
        .out_err    (out_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the full output record {valid,lane,first,middle,last,eop,err}
    task automatic chk_rec(input string tag, input int lane, input int f, input int m,
                           input int la, input int er);
        logic [31:0] obs;
        logic [31:0] exp;
        obs = 32'({out_valid, out_lane, out_first, out_middle, out_last, out_eop, out_err});
        exp = 32'({1'b1, 2'(lane), 2'(f), 4'(m), 2'(la), 1'(lane == 3), 1'(er)});
        chk(tag, obs, exp);
    endtask

    initial begin
        int mids1 [4];
        int mids2 [4];
        int idx;
        int cyc_n;
        logic pat [4];
        mids1 = '{10, 10, 10, 10};
        mids2 = '{6, 6, 6, 10};
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset
        rst = 1'b1; in_valid = 1'b0; in_all = '0; out_ready = 1'b0;
        cyc(); cyc();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_data", 32'({out_lane, out_first, out_middle, out_last, out_eop}), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_rel_in_ready", 32'(in_ready), 32'd1);

        // Idle hold
        for (int c = 0; c < 10; c++) begin
            cyc();
            chk($sformatf("idle_valid_%0d", c), 32'(out_valid), 32'd0);
            chk($sformatf("idle_ready_%0d", c), 32'(in_ready), 32'd1);
        end

        // Nominal word
        in_valid = 1'b1; in_all = W1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0; in_all = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk_rec($sformatf("nom_l%0d", k), k, k, mids1[k], 3 - k, 0);
            chk($sformatf("nom_rdy_l%0d", k), 32'(in_ready), 32'(k == 3));
            cyc();
        end
        chk("nom_end_valid", 32'(out_valid), 32'd0);
        chk("nom_err_count", 32'(err_count), 32'd0);

        // Back-to-back words with in_valid held high
        in_valid = 1'b1; in_all = W1;
        cyc();
        for (int k = 0; k < 8; k++) begin
            if (k == 2) in_all = W2;
            if (k == 4) in_valid = 1'b0;
            #1;
            if (k < 4) chk_rec($sformatf("b2b_r%0d", k), k, k, mids1[k], 3 - k, 0);
            else       chk_rec($sformatf("b2b_r%0d", k), k - 4, k - 4, mids2[k-4], 7 - k, 0);
            if (k < 3) chk($sformatf("b2b_holdoff_%0d", k), 32'(in_ready), 32'd0);
            if (k == 3) chk("b2b_accept", 32'(in_ready), 32'd1);
            cyc();
        end
        chk("b2b_end_valid", 32'(out_valid), 32'd0);

        // Backpressure: out_ready 1,0,0,1,... with W2 waiting upstream
        in_valid = 1'b1; in_all = W1; out_ready = 1'b1;
        cyc();
        in_all = W2;
        idx = 0; cyc_n = 0;
        while (idx < 4 && cyc_n < 40) begin
            out_ready = pat[cyc_n % 4];
            #1;
            chk_rec($sformatf("bp_c%0d", cyc_n), idx, idx, mids1[idx], 3 - idx, 0);
            chk($sformatf("bp_rdy_c%0d", cyc_n), 32'(in_ready), 32'(idx == 3 && out_ready));
            if (out_ready) idx++;
            cyc_n++;
            cyc();
        end
        chk("bp_cycles", 32'(cyc_n), 32'd8);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk_rec($sformatf("bp_w2_l%0d", k), k, k, mids2[k], 3 - k, 0);
            cyc();
        end
        chk("bp_end_valid", 32'(out_valid), 32'd0);

        // Error detect: lane 2 only
        in_valid = 1'b1; in_all = WERR;
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk_rec($sformatf("err_l%0d", k), k, (k == 2) ? 0 : k, 10, 3 - k, int'(k == 2));
            cyc();
        end
        chk("err_count_1", 32'(err_count), 32'd1);

        // 299 more error words back-to-back -> 300 errors, saturates at 255
        in_valid = 1'b1;
        cyc();
        for (int w = 0; w < 299; w++) begin
            for (int c = 0; c < 4; c++) begin
                in_valid = (c == 3) && (w < 298);
                cyc();
            end
        end
        chk("err_sat_valid", 32'(out_valid), 32'd0);
        chk("err_sat_255", 32'(err_count), 32'd255);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) cyc();
        chk("err_sat_hold", 32'(err_count), 32'd255);

        // Reset mid-word after the lane-1 transfer
        in_valid = 1'b1; in_all = W1;
        cyc();
        in_valid = 1'b0;
        cyc(); cyc();
        #1;
        chk("mid_pre_lane", 32'(out_lane), 32'd2);
        rst = 1'b1;
        cyc();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_errcnt", 32'(err_count), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", 32'(in_ready), 32'd1);
        chk("mid_rel_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_all = W2;
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk_rec($sformatf("mid_new_l%0d", k), k, k, mids2[k], 3 - k, 0);
            cyc();
        end
        chk("mid_end_valid", 32'(out_valid), 32'd0);
        chk("mid_end_errcnt", 32'(err_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
